// File: rtl/operand_fetch_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | operand_fetch_if : upstream, register-file, writeback and downstream |
// | signals of the operand fetch stage.                 Rev 1.0          |
// +----------------------------------------------------------------------+
interface operand_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [4:0]            in_rd;
  logic                  in_rd_we;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [4:0]            rf_addr_rs1;
  logic [4:0]            rf_addr_rs2;
  logic [DATA_WIDTH-1:0] rf_data_rs1;
  logic [DATA_WIDTH-1:0] rf_data_rs2;
  logic                  wb_enable;
  logic [4:0]            wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_rs1_data;
  logic [DATA_WIDTH-1:0] out_rs2_data;
  logic [4:0]            out_rd;
  logic                  out_rd_we;
  logic [DATA_WIDTH-1:0] out_pc;

  modport slave (
    input  flush, in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_pc,
    input  rf_data_rs1, rf_data_rs2, wb_enable, wb_addr, wb_data, out_ready,
    output in_ready, rf_addr_rs1, rf_addr_rs2,
    output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we, out_pc
  );

  modport master (
    output flush, in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_pc,
    output rf_data_rs1, rf_data_rs2, wb_enable, wb_addr, wb_data, out_ready,
    input  in_ready, rf_addr_rs1, rf_addr_rs2,
    input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we, out_pc
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | operand_fetch : single-buffer operand fetch with RAW scoreboard and  |
// | writeback bypass.                                   Rev 1.0          |
// +----------------------------------------------------------------------+
module operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  wire logic        clock,
  input  wire logic        reset,
  operand_fetch_if.slave   io_bus
);

  localparam int c_AW = 5;

  function automatic logic f_pending(input logic [c_AW-1:0] a,
                                     input logic [REG_COUNT-1:0] p);
    logic v;
    v = 1'b0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (a == c_AW'(i)) v = p[i];
    end
    return v;
  endfunction

  logic [REG_COUNT-1:0]  r_pending;
  logic                  r_valid;
  logic [c_AW-1:0]       r_rs1;
  logic [c_AW-1:0]       r_rs2;
  logic [c_AW-1:0]       r_rd;
  logic                  r_rd_we;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_byp1;
  logic                  r_byp2;
  logic [DATA_WIDTH-1:0] r_byp1_data;
  logic [DATA_WIDTH-1:0] r_byp2_data;
  logic                  r_held;
  logic [DATA_WIDTH-1:0] r_hold1;
  logic [DATA_WIDTH-1:0] r_hold2;

  logic                  w_blk_rs1;
  logic                  w_blk_rs2;
  logic                  w_blk_rd;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_sb_set;
  logic                  w_byp1;
  logic                  w_byp2;
  logic [DATA_WIDTH-1:0] w_fresh1;
  logic [DATA_WIDTH-1:0] w_fresh2;

  // A same-cycle writeback to a pending register unblocks it immediately.
  assign w_blk_rs1 = f_pending(io_bus.in_rs1, r_pending) &&
                     !(io_bus.wb_enable && io_bus.wb_addr == io_bus.in_rs1);
  assign w_blk_rs2 = f_pending(io_bus.in_rs2, r_pending) &&
                     !(io_bus.wb_enable && io_bus.wb_addr == io_bus.in_rs2);
  assign w_blk_rd  = f_pending(io_bus.in_rd, r_pending) &&
                     !(io_bus.wb_enable && io_bus.wb_addr == io_bus.in_rd);

  assign w_in_ready = reset && !w_blk_rs1 && !w_blk_rs2 &&
                      !(io_bus.in_rd_we && w_blk_rd) &&
                      (!r_valid || io_bus.out_ready) && !io_bus.flush;
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_fire     = r_valid && io_bus.out_ready;
  assign w_sb_set   = w_fire && !io_bus.flush && r_rd_we && (r_rd != '0);

  // The register file returns the pre-write value during a writeback cycle.
  assign w_byp1 = io_bus.wb_enable && (io_bus.wb_addr == io_bus.in_rs1) &&
                  (io_bus.in_rs1 != '0);
  assign w_byp2 = io_bus.wb_enable && (io_bus.wb_addr == io_bus.in_rs2) &&
                  (io_bus.in_rs2 != '0);

  assign w_fresh1 = (r_rs1 == '0) ? '0 : (r_byp1 ? r_byp1_data : io_bus.rf_data_rs1);
  assign w_fresh2 = (r_rs2 == '0) ? '0 : (r_byp2 ? r_byp2_data : io_bus.rf_data_rs2);

  assign io_bus.in_ready     = w_in_ready;
  assign io_bus.rf_addr_rs1  = io_bus.in_rs1;
  assign io_bus.rf_addr_rs2  = io_bus.in_rs2;
  assign io_bus.out_valid    = r_valid;
  assign io_bus.out_rs1_data = r_held ? r_hold1 : w_fresh1;
  assign io_bus.out_rs2_data = r_held ? r_hold2 : w_fresh2;
  assign io_bus.out_rd       = r_rd;
  assign io_bus.out_rd_we    = r_rd_we;
  assign io_bus.out_pc       = r_pc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending[0] <= 1'b0;
      for (int i = 1; i < REG_COUNT; i++) begin
        if (w_sb_set && r_rd == c_AW'(i))
          r_pending[i] <= 1'b1;
        else if (io_bus.wb_enable && io_bus.wb_addr == c_AW'(i))
          r_pending[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rd_we     <= 1'b0;
      r_pc        <= '0;
      r_byp1      <= 1'b0;
      r_byp2      <= 1'b0;
      r_byp1_data <= '0;
      r_byp2_data <= '0;
      r_held      <= 1'b0;
      r_hold1     <= '0;
      r_hold2     <= '0;
    end else begin
      if (io_bus.flush)
        r_valid <= 1'b0;
      else if (w_accept)
        r_valid <= 1'b1;
      else if (w_fire)
        r_valid <= 1'b0;

      if (w_accept) begin
        r_rs1       <= io_bus.in_rs1;
        r_rs2       <= io_bus.in_rs2;
        r_rd        <= io_bus.in_rd;
        r_rd_we     <= io_bus.in_rd_we;
        r_pc        <= io_bus.in_pc;
        r_byp1      <= w_byp1;
        r_byp2      <= w_byp2;
        r_byp1_data <= io_bus.wb_data;
        r_byp2_data <= io_bus.wb_data;
        r_held      <= 1'b0;
      end else if (io_bus.flush || w_fire) begin
        r_held      <= 1'b0;
      end else if (r_valid && !r_held) begin
        // Stalled: rf_data will follow the next upstream address, so freeze.
        r_held      <= 1'b1;
        r_hold1     <= w_fresh1;
        r_hold2     <= w_fresh2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_operand_fetch : directed vector bench for operand_fetch. Rev 1.0  |
// +----------------------------------------------------------------------+
module tb_operand_fetch;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  operand_fetch_if #(.DATA_WIDTH(DW)) bus ();

  operand_fetch #(.DATA_WIDTH(DW), .REG_COUNT(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  // Register file model: one-cycle read latency, write visible after the edge.
  logic [DW-1:0] rf [32];
  always @(posedge clock) begin
    bus.rf_data_rs1 <= rf[bus.rf_addr_rs1];
    bus.rf_data_rs2 <= rf[bus.rf_addr_rs2];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    if (bus.wb_enable) rf[bus.wb_addr] = bus.wb_data;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_rd_we = we;
    bus.in_pc    = pc;
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{rs1: 5'd5,  rs2: 5'd6,  rd: 5'd1, we: 1'b0, pc: 32'h100, e1: 32'h11,   e2: 32'h22};
    vecs[1] = '{rs1: 5'd6,  rs2: 5'd5,  rd: 5'd2, we: 1'b0, pc: 32'h104, e1: 32'h22,   e2: 32'h11};
    vecs[2] = '{rs1: 5'd0,  rs2: 5'd31, rd: 5'd3, we: 1'b0, pc: 32'h108, e1: 32'h0,    e2: 32'h101F};
    vecs[3] = '{rs1: 5'd12, rs2: 5'd0,  rd: 5'd0, we: 1'b1, pc: 32'h10C, e1: 32'h100C, e2: 32'h0};
    vecs[4] = '{rs1: 5'd31, rs2: 5'd1,  rd: 5'd0, we: 1'b1, pc: 32'h110, e1: 32'h101F, e2: 32'h1001};

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hFFFF_FFFF;
    rf[5] = 32'h11;
    rf[6] = 32'h22;

    bus.flush     = 1'b0;
    bus.wb_enable = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;
    drive(1'b1, 5'd5, 5'd6, 5'd1, 1'b0, 32'h100);

    // Reset
    #1;
    chk("reset_in_ready", bus.in_ready, 1'b0);
    cyc();
    cyc();
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_rs1",   bus.out_rs1_data, 32'h0);
    chk("reset_out_pc",    bus.out_pc, 32'h0);
    chk("reset_out_rd",    bus.out_rd, 5'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cyc();

    // Back-to-back issue from the vector table
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].we, vecs[k].pc);
      #1;
      chk($sformatf("vec%0d_in_ready", k), bus.in_ready, 1'b1);
      cyc();
      chk($sformatf("vec%0d_out_valid", k), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_rs1", k), bus.out_rs1_data, vecs[k].e1);
      chk($sformatf("vec%0d_rs2", k), bus.out_rs2_data, vecs[k].e2);
      chk($sformatf("vec%0d_pc", k), bus.out_pc, vecs[k].pc);
      chk($sformatf("vec%0d_rd", k), {bus.out_rd_we, bus.out_rd}, {vecs[k].we, vecs[k].rd});
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("drain_out_valid", bus.out_valid, 1'b0);

    // RAW stall resolved by writeback bypass
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 32'h200);
    cyc();
    chk("raw_prod_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    cyc();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h208);
    #1;
    chk("waw_stall", bus.in_ready, 1'b0);
    drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 32'h204);
    #1;
    chk("raw_stall0", bus.in_ready, 1'b0);
    cyc();
    chk("raw_stall1", bus.in_ready, 1'b0);
    chk("raw_stall_valid", bus.out_valid, 1'b0);
    cyc();
    bus.wb_enable = 1'b1;
    bus.wb_addr   = 5'd7;
    bus.wb_data   = 32'hABCD;
    #1;
    chk("raw_wb_ready", bus.in_ready, 1'b1);
    cyc();
    bus.wb_enable = 1'b0;
    bus.in_valid  = 1'b0;
    chk("raw_cons_valid", bus.out_valid, 1'b1);
    chk("raw_bypass", bus.out_rs1_data, 32'hABCD);
    chk("raw_cons_pc", bus.out_pc, 32'h204);
    cyc();

    // Backpressure: operands must stay frozen while rf_data moves on
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 32'h300);
    cyc();
    drive(1'b1, 5'd10, 5'd11, 5'd0, 1'b0, 32'h304);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_valid", k), bus.out_valid, 1'b1);
      chk($sformatf("bp%0d_rs1", k), bus.out_rs1_data, 32'h1003);
      chk($sformatf("bp%0d_rs2", k), bus.out_rs2_data, 32'h1004);
      chk($sformatf("bp%0d_pc", k), bus.out_pc, 32'h300);
      chk($sformatf("bp%0d_in_ready", k), bus.in_ready, 1'b0);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", bus.out_valid, 1'b1);
    chk("bp_next_rs1", bus.out_rs1_data, 32'h100A);
    chk("bp_next_rs2", bus.out_rs2_data, 32'h100B);
    chk("bp_next_pc", bus.out_pc, 32'h304);
    cyc();
    chk("bp_drain_valid", bus.out_valid, 1'b0);

    // Scoreboard set wins over same-cycle clear
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h400);
    cyc();
    bus.in_valid  = 1'b0;
    bus.wb_enable = 1'b1;
    bus.wb_addr   = 5'd9;
    bus.wb_data   = 32'h99;
    cyc();
    bus.wb_enable = 1'b0;
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 32'h404);
    #1;
    chk("race_set_wins", bus.in_ready, 1'b0);

    // Flush of a staged, stalled instruction
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 32'h500);
    #1;
    chk("flush_pre_ready", bus.in_ready, 1'b1);
    cyc();
    chk("flush_pre_valid", bus.out_valid, 1'b1);
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", bus.in_ready, 1'b0);
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_clears", bus.out_valid, 1'b0);
    drive(1'b0, 5'd10, 5'd0, 5'd0, 1'b0, 32'h504);
    #1;
    chk("flush_no_set", bus.in_ready, 1'b1);
    drive(1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 32'h504);
    #1;
    chk("flush_keeps_pending", bus.in_ready, 1'b0);

    // Reset mid-operation with a pending bit and a staged instruction
    drive(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 32'h600);
    cyc();
    chk("rst_pre_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    cyc();
    chk("rst_discard", bus.out_valid, 1'b0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_rd", {bus.out_rd_we, bus.out_rd}, 6'd0);
    chk("rst_rs1", bus.out_rs1_data, 32'h0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 32'h700);
    #1;
    chk("rst_clears_sb", bus.in_ready, 1'b1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and PC width.
REQ-002 SHALL have parameter REG_COUNT, default 32, architectural registers (5-bit addresses).
REQ-003 SHALL have ports, in order:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  drops the staged instruction.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  upstream accept.
- in_rs1, in_rs2, in_rd  in  5 each  source and destination addresses.
- in_rd_we  in  1  instruction writes rd.
- in_pc  in  DATA_WIDTH  instruction PC.
- rf_addr_rs1, rf_addr_rs2  out  5 each  register-file read addresses.
- rf_data_rs1, rf_data_rs2  in  DATA_WIDTH each  register-file read data, valid one cycle after address.
- wb_enable  in  1  writeback strobe (same strobe the register file sees).
- wb_addr  in  5  writeback address.
- wb_data  in  DATA_WIDTH  writeback data.
- out_valid  out  1  downstream instruction valid.
- out_ready  in  1  downstream accept.
- out_rs1_data, out_rs2_data  out  DATA_WIDTH each  resolved operands.
- out_rd  out  5  destination address.
- out_rd_we  out  1  destination write flag.
- out_pc  out  DATA_WIDTH  instruction PC.

Function
REQ-004 SHALL use a single stage buffer; out_valid SHALL be a registered flag.
REQ-005 SHALL drive rf_addr_rs1/rs2 combinationally from in_rs1/in_rs2 every cycle.
REQ-006 SHALL keep a REG_COUNT-bit pending scoreboard; bit 0 SHALL never be set.
REQ-007 SHALL set pending[out_rd] on an out_valid && out_ready cycle when out_rd_we=1 and out_rd!=0.
REQ-008 SHALL clear pending[wb_addr] on wb_enable; set SHALL win when set and clear target the same bit in the same cycle.
REQ-009 SHALL define a source as blocked when its pending bit is set and it is not cleared by wb_enable in the same cycle; x0 SHALL never be blocked.
REQ-010 SHALL assert in_ready = !blocked(rs1) && !blocked(rs2) && !(in_rd_we && blocked(in_rd)) && (!out_valid || out_ready) && !flush.
REQ-011 SHALL accept the instruction on in_valid && in_ready and capture rd, rd_we and pc into the stage; out_valid SHALL rise on the next cycle.
REQ-012 SHALL set a per-operand bypass flag and latch wb_data at accept when wb_enable && wb_addr==rs && rs!=0; the register file returns stale data in that cycle.
REQ-013 SHALL present operands in the first valid cycle as: 0 if address==0, else the bypass data if flagged, else rf_data.
REQ-014 SHALL latch the presented operands into hold registers while out_valid && !out_ready; held values SHALL remain stable until consumed.
REQ-015 SHALL deassert out_valid on the cycle after a handshake unless a new instruction was accepted that cycle; back-to-back throughput SHALL be 1 per cycle.
REQ-016 SHALL, on flush=1, clear out_valid next cycle, accept nothing, and leave the scoreboard unchanged except for wb clears.
REQ-017 SHALL hold all stage outputs when out_valid=0; their values are don't-care except out_valid.

Reset
REQ-018 SHALL, while reset=0 at a clock edge, clear out_valid, the scoreboard, the bypass flags, and all out_* data and address registers to 0.
REQ-019 SHALL discard a staged instruction when reset is applied mid-operation; no scoreboard bit SHALL survive reset.
REQ-020 SHALL force in_ready=0 during the reset cycle.

Verification
REQ-021 Test basic issue: rf x5=0x11, x6=0x22, issue rs1=5, rs2=6, out_ready=1 -> next cycle out_valid=1, operands 0x11/0x22.
REQ-022 Test RAW stall: issue rd=7 (we=1), then rs1=7 -> in_ready=0 until wb_enable addr=7 data=0xABCD; in that cycle accept occurs -> out_rs1_data=0xABCD (bypass).
REQ-023 Test x0: rs1=0 while rf_data_rs1=0xFFFFFFFF -> out_rs1_data=0; rd=0 we=1 issued -> no pending bit.
REQ-024 Test backpressure: out_ready=0 for 3 cycles while rf_data changes -> outputs stable, in_ready=0; release -> one handshake, next instruction follows.
REQ-025 Test set/clear race: handshake rd=9 coinciding with wb addr=9 -> pending[9]=1 afterward.
REQ-026 Test flush and reset: flush with staged valid -> out_valid=0 next cycle; reset=0 with pending bits set -> scoreboard 0, out_valid 0.
